ps2_packet_tracker: RTL and testbench
=====================================

Name: ps2_packet_tracker

Overview:
Sits directly upstream of the mouse-to-screen painter. Consumes the byte stream from the PS/2 receiver, frames standard 3-byte mouse packets and accumulates signed X/Y deltas into absolute, clamped cursor coordinates. Its x_pos/y_pos outputs drive the painter's PS2_Xdata/PS2_Ydata inputs directly. It also exports button state and one-cycle packet and sync-error strobes.

Parameters:
X_MAX, 63, largest legal x_pos (inclusive); must be less than 511
Y_MAX, 63, largest legal y_pos (inclusive); must be less than 511
X_INIT, 32, x_pos after reset
Y_INIT, 32, y_pos after reset
Y_INVERT, 1, 1 = mouse-up (positive dY) decreases y_pos (screen row 0 at top); 0 = added as-is
TIMEOUT_CYCLES, 50000, idle clk cycles inside a packet before it is abandoned

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
rx_data  in  8  byte from PS/2 receiver
rx_valid  in  1  one-cycle strobe, rx_data valid this cycle
x_pos  out  9  absolute X, 0..X_MAX
y_pos  out  9  absolute Y, 0..Y_MAX
buttons  out  3  {middle,right,left} from last accepted packet
pkt_valid  out  1  one-cycle pulse when x_pos/y_pos/buttons update
sync_err  out  1  one-cycle pulse on rejected byte0 or timeout

Behaviour:
- Reset: x_pos=X_INIT, y_pos=Y_INIT, buttons=0, pkt_valid=0, sync_err=0, state=WAIT_B0, timeout counter=0, byte registers=0. Reset mid-packet discards the partial packet.
- States:
  - WAIT_B0: on rx_valid, if rx_data[3]==1, store byte0 and go to WAIT_B1. Otherwise pulse sync_err next cycle and stay.
  - WAIT_B1: on rx_valid, store dX and go to WAIT_B2.
  - WAIT_B2: on rx_valid, store dY and go to UPDATE.
  - UPDATE: single cycle. Registers the new x_pos, y_pos and buttons (byte0[2:0]), pulses pkt_valid, then goes to WAIT_B0. An rx_valid arriving in UPDATE is processed exactly as in WAIT_B0, so the next packet's byte0 is not lost.
- Latency: rx_valid for byte 2 sampled at edge k -> new outputs and pkt_valid=1 after edge k+1. pkt_valid is low in every other cycle.
- Outputs hold their values between packets.
- Timeout:
  - Counter clears on every accepted byte and counts only in WAIT_B1/WAIT_B2.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: go to WAIT_B0 and pulse sync_err.
  - If rx_valid coincides with the terminal count, the byte wins and no timeout occurs.
- Delta decode:
  - dX = {byte0[4], byte1}, 9-bit two's complement.
  - dY = {byte0[5], byte2}, 9-bit two's complement.
  - X overflow (byte0[6]) forces dX=0; Y overflow (byte0[7]) forces dY=0. Buttons still update.
- Arithmetic: 11-bit signed.
  - sum_x = zero-extended x_pos + sign-extended dX.
  - sum_y = y_pos - dY if Y_INVERT, else y_pos + dY.
  - Clamp: sum<0 -> 0; sum>MAX -> MAX; else sum[8:0]. No wrap-around ever.
- sync_err and pkt_valid never assert in the same cycle, except when a rejected byte0 arrives during UPDATE; both pulses are then permitted.

Decomposition:
- Shared package ps2_pkg holds:
  - state encodings (WAIT_B0, WAIT_B1, WAIT_B2, UPDATE; 2-bit);
  - byte0 bit indices (BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7);
  - packet length 3.
- One combinational sub-module, ps2_axis_clamp (inputs: pos, delta, ovf, negate, MAX parameter; output: clamped pos), instantiated once for X and once for Y.

Test Plan:
1. Reset, then packet 08,05,03 with Y_INVERT=1 -> pkt_valid one cycle after third strobe; x_pos=37, y_pos=29, buttons=0.
2. From 37/29, packet 39,F0,F0 (X and Y both negative, left button) -> x_pos=21, y_pos=45, buttons=001.
3. Clamping: from x=60, packet 08,7F,00 -> x_pos=63. Then packet 18,80,00 (dX=-128) -> x_pos=0. Neither wraps.
4. Sync: bytes 00,08,01,01 -> sync_err pulse after the first byte only; the packet framed as 08,01,01 gives x_pos+1, y_pos-1.
5. Timeout (TIMEOUT_CYCLES=100): send 08, then idle 100 cycles -> sync_err pulse, outputs unchanged. A following full packet decodes normally. Also check that a byte arriving at count 99 is accepted.
6. Overflow plus reset: packet 48,FF,05 -> x unchanged, y-=5. Assert reset between bytes 1 and 2 -> outputs return to 32/32 and the next 3 bytes frame as a new packet.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet tracker: FSM states,
// byte0 field positions and packet length.
package ps2_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } ps2_state_e;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int SYNC    = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;
  localparam int PKT_LEN = 3;

endpackage

// File: rtl/ps2_axis_clamp.sv
// One axis of cursor arithmetic: applies a 9-bit signed delta (optionally
// negated or suppressed on overflow) and saturates the result to 0..MAX.
module ps2_axis_clamp #(
  parameter int unsigned MAX = 63
) (
  input  logic [8:0] pos,
  input  logic [8:0] delta,
  input  logic       ovf,
  input  logic       negate,
  output logic [8:0] clamped
);

  localparam logic signed [10:0] MAX_S = 11'(MAX);
  localparam logic        [8:0]  MAX_P = 9'(MAX);

  logic signed [10:0] d_sel;
  logic signed [10:0] d_eff;
  logic signed [10:0] sum;

  // 11 bits hold every pos +/- delta combination without wrapping
  always_comb begin
    d_sel = ovf ? 11'sd0 : $signed({{2{delta[8]}}, delta});
    d_eff = negate ? (11'sd0 - d_sel) : d_sel;
    sum   = $signed({2'b00, pos}) + d_eff;
    if (sum < 11'sd0) begin
      clamped = 9'd0;
    end else if (sum > MAX_S) begin
      clamped = MAX_P;
    end else begin
      clamped = sum[8:0];
    end
  end

endmodule

// File: rtl/ps2_packet_tracker.sv
// Frames 3-byte PS/2 mouse packets and integrates their deltas into
// clamped absolute cursor coordinates with button state.
module ps2_packet_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned X_MAX          = 63,
  parameter int unsigned Y_MAX          = 63,
  parameter int unsigned X_INIT         = 32,
  parameter int unsigned Y_INIT         = 32,
  parameter bit          Y_INVERT       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [8:0] x_pos,
  output logic [8:0] y_pos,
  output logic [2:0] buttons,
  output logic       pkt_valid,
  output logic       sync_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state, state_next;
  logic [7:0]    byte0, byte1, byte2;
  logic [CW-1:0] cnt, cnt_next;
  logic          ld_b0, ld_b1, ld_b2;
  logic          sync_err_next, pkt_valid_next;
  logic [8:0]    x_clamp, y_clamp;

  ps2_axis_clamp #(.MAX(X_MAX)) u_clamp_x (
    .pos    (x_pos),
    .delta  ({byte0[XSIGN], byte1}),
    .ovf    (byte0[XOVF]),
    .negate (1'b0),
    .clamped(x_clamp)
  );

  ps2_axis_clamp #(.MAX(Y_MAX)) u_clamp_y (
    .pos    (y_pos),
    .delta  ({byte0[YSIGN], byte2}),
    .ovf    (byte0[YOVF]),
    .negate (Y_INVERT),
    .clamped(y_clamp)
  );

  // UPDATE also accepts a byte0 so back-to-back packets are not dropped
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    ld_b0          = 1'b0;
    ld_b1          = 1'b0;
    ld_b2          = 1'b0;
    sync_err_next  = 1'b0;
    pkt_valid_next = 1'b0;
    case (state)
      WAIT_B0, UPDATE: begin
        pkt_valid_next = (state == UPDATE);
        cnt_next       = '0;
        if (rx_valid && rx_data[SYNC]) begin
          ld_b0      = 1'b1;
          state_next = WAIT_B1;
        end else if (rx_valid) begin
          sync_err_next = 1'b1;
          state_next    = WAIT_B0;
        end else begin
          state_next = WAIT_B0;
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (rx_valid) begin
          ld_b1      = (state == WAIT_B1);
          ld_b2      = (state == WAIT_B2);
          cnt_next   = '0;
          state_next = (state == WAIT_B1) ? WAIT_B2 : UPDATE;
        end else if (cnt == CNT_TERM) begin
          cnt_next      = '0;
          sync_err_next = 1'b1;
          state_next    = WAIT_B0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = WAIT_B0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_B0;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      byte0     <= 8'd0;
      byte1     <= 8'd0;
      byte2     <= 8'd0;
      x_pos     <= 9'(X_INIT);
      y_pos     <= 9'(Y_INIT);
      buttons   <= 3'd0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      pkt_valid <= pkt_valid_next;
      sync_err  <= sync_err_next;
      if (ld_b0) byte0 <= rx_data;
      if (ld_b1) byte1 <= rx_data;
      if (ld_b2) byte2 <= rx_data;
      if (pkt_valid_next) begin
        x_pos   <= x_clamp;
        y_pos   <= y_clamp;
        buttons <= byte0[BTN_M:BTN_L];
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_tracker.sv
// Directed bench for ps2_packet_tracker: packet table plus hand-written
// sync, timeout, overflow, reset and back-to-back sequences.
module tb_ps2_packet_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [8:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic       pkt_valid, sync_err;

  int nvec = 0;
  int nmis = 0;
  int sync_cnt = 0;
  int pkt_cnt = 0;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int ex, ey, eb;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  ps2_packet_tracker #(.TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .buttons  (buttons),
    .pkt_valid(pkt_valid),
    .sync_err (sync_err)
  );

  // pulse counters sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (sync_err)  sync_cnt <= sync_cnt + 1;
    if (pkt_valid) pkt_cnt  <= pkt_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  initial begin
    int s0, p0;
    vecs[0]  = '{8'h08, 8'h05, 8'h03, 37, 29, 0};
    vecs[1]  = '{8'h39, 8'hF0, 8'hF0, 21, 45, 1};
    vecs[2]  = '{8'h08, 8'h27, 8'h00, 60, 45, 0};
    vecs[3]  = '{8'h08, 8'h7F, 8'h00, 63, 45, 0};
    vecs[4]  = '{8'h18, 8'h80, 8'h00,  0, 45, 0};
    vecs[5]  = '{8'h0F, 8'h00, 8'h00,  0, 45, 7};
    vecs[6]  = '{8'h28, 8'h00, 8'h80,  0, 63, 0};
    vecs[7]  = '{8'h08, 8'h00, 8'h7F,  0,  0, 0};
    vecs[8]  = '{8'h28, 8'h00, 8'hE2,  0, 30, 0};
    vecs[9]  = '{8'h48, 8'hFF, 8'h05,  0, 25, 0};
    vecs[10] = '{8'h88, 8'h03, 8'h7F,  3, 25, 0};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset_x", int'(x_pos), 32);
    check("reset_y", int'(y_pos), 32);
    check("reset_btn", int'(buttons), 0);
    check("reset_pkt", int'(pkt_valid), 0);
    check("reset_sync", int'(sync_err), 0);

    s0 = sync_cnt;
    for (int i = 0; i < 11; i++) begin
      p0 = pkt_cnt;
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check($sformatf("v%0d_pkt_early", i), int'(pkt_valid), 0);
      idle(1);
      check($sformatf("v%0d_pkt", i), int'(pkt_valid), 1);
      check($sformatf("v%0d_x", i), int'(x_pos), vecs[i].ex);
      check($sformatf("v%0d_y", i), int'(y_pos), vecs[i].ey);
      check($sformatf("v%0d_btn", i), int'(buttons), vecs[i].eb);
      check($sformatf("v%0d_pkt_count", i), pkt_cnt - p0, 1);
    end
    check("table_sync_count", sync_cnt - s0, 0);

    // bad byte0 rejected, then a clean packet frames after it
    s0 = sync_cnt;
    send_byte(8'h00);
    check("sync_pulse", int'(sync_err), 1);
    send_pkt(8'h08, 8'h01, 8'h01);
    idle(1);
    check("sync_x", int'(x_pos), 4);
    check("sync_y", int'(y_pos), 24);
    check("sync_count", sync_cnt - s0, 1);

    // abandoned packet after 100 idle cycles
    s0 = sync_cnt;
    p0 = pkt_cnt;
    send_byte(8'h08);
    idle(99);
    check("tmo_not_yet", int'(sync_err), 0);
    idle(1);
    check("tmo_pulse", int'(sync_err), 1);
    check("tmo_x_hold", int'(x_pos), 4);
    check("tmo_y_hold", int'(y_pos), 24);
    check("tmo_no_pkt", pkt_cnt - p0, 0);
    send_pkt(8'h08, 8'h02, 8'h00);
    idle(1);
    check("tmo_next_x", int'(x_pos), 6);
    check("tmo_next_y", int'(y_pos), 24);

    // byte at terminal count wins
    send_byte(8'h08);
    idle(99);
    send_byte(8'h03);
    send_byte(8'h00);
    idle(1);
    check("term_x", int'(x_pos), 9);
    check("term_y", int'(y_pos), 24);
    check("term_sync_count", sync_cnt - s0, 1);

    // reset mid-packet discards partial bytes
    send_byte(8'h08);
    send_byte(8'h01);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_mid_x", int'(x_pos), 32);
    check("rst_mid_y", int'(y_pos), 32);
    check("rst_mid_btn", int'(buttons), 0);
    send_pkt(8'h08, 8'h04, 8'h02);
    idle(1);
    check("rst_next_x", int'(x_pos), 36);
    check("rst_next_y", int'(y_pos), 30);

    // second byte0 arrives during UPDATE
    p0 = pkt_cnt;
    send_pkt(8'h08, 8'h01, 8'h00);
    send_pkt(8'h09, 8'h01, 8'h00);
    idle(1);
    check("b2b_x", int'(x_pos), 38);
    check("b2b_btn", int'(buttons), 1);
    check("b2b_pkt_count", pkt_cnt - p0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
